// File: rtl/nes_joypad_port_if.sv
`default_nettype none
// ============================================================================
// Module      : nes_joypad_port_if
// Description : Bundle of gamepad snapshot inputs and NES CPU port signals
//               for nes_joypad_port. The slave side is the port block; the
//               master side is whatever drives it (gamepad readers + CPU).
// Revision    : 1.0 - initial release
// ============================================================================
interface nes_joypad_port_if;
  logic [7:0] i_p1_buttons;
  logic       i_p1_valid;
  logic [7:0] i_p2_buttons;
  logic       i_p2_valid;
  logic       i_cpu_strobe_we;
  logic       i_cpu_wdata0;
  logic       i_cpu_rd;
  logic       i_cpu_rd_port;
  logic       o_cpu_rdata;
  logic       o_p1_connected;
  logic       o_p2_connected;

  modport slave (
    input  i_p1_buttons, i_p1_valid, i_p2_buttons, i_p2_valid,
    input  i_cpu_strobe_we, i_cpu_wdata0, i_cpu_rd, i_cpu_rd_port,
    output o_cpu_rdata, o_p1_connected, o_p2_connected
  );

  modport master (
    output i_p1_buttons, i_p1_valid, i_p2_buttons, i_p2_valid,
    output i_cpu_strobe_we, i_cpu_wdata0, i_cpu_rd, i_cpu_rd_port,
    input  o_cpu_rdata, o_p1_connected, o_p2_connected
  );
endinterface
`default_nettype wire

// File: rtl/nes_joypad_port.sv
`default_nettype none
// ============================================================================
// Module      : nes_joypad_port
// Description : NES $4016/$4017 controller ports for two players. Captures
//               button snapshots on the rising edge of each player's valid
//               level, filters opposing D-pad presses, serves them through
//               the strobe-and-shift protocol and flags silent controllers.
// Revision    : 1.0 - initial release
// ============================================================================
module nes_joypad_port #(
  parameter int TIMEOUT_CYCLES = 1350000,
  parameter bit MASK_OPPOSING  = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  nes_joypad_port_if.slave   bus
);

  localparam int                WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]   c_wd_max = WD_W'(TIMEOUT_CYCLES);

  logic [7:0] w_btn   [2];
  logic       w_valid [2];
  logic [1:0] w_sh0;
  logic [1:0] w_conn;

  logic       strobe_q;
  logic       rdata_q;

  assign w_btn[0]   = bus.i_p1_buttons;
  assign w_btn[1]   = bus.i_p2_buttons;
  assign w_valid[0] = bus.i_p1_valid;
  assign w_valid[1] = bus.i_p2_valid;

  // Drops Up+Down and Left+Right pairs; a real pad cannot press both.
  function automatic logic [7:0] mask_dpad(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (MASK_OPPOSING) begin
      if (b[4] && b[5]) r[5:4] = 2'b00;
      if (b[6] && b[7]) r[7:6] = 2'b00;
    end
    return r;
  endfunction

  generate
    for (genvar p = 0; p < 2; p++) begin : g_player
      logic            valid_q;
      logic [7:0]      held_q;
      logic [7:0]      sh_q;
      logic [WD_W-1:0] wd_q;
      logic            conn_q;
      logic            w_capture;
      logic            w_rd_sel;
      logic [WD_W-1:0] w_wd_inc;

      assign w_capture = w_valid[p] & ~valid_q;
      assign w_rd_sel  = bus.i_cpu_rd & (bus.i_cpu_rd_port == 1'(p));
      assign w_wd_inc  = wd_q + 1'b1;
      assign w_sh0[p]  = sh_q[0];
      assign w_conn[p] = conn_q;

      // Snapshot capture, watchdog and the serial shift register of one pad.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          valid_q <= 1'b0;
          held_q  <= 8'h00;
          sh_q    <= 8'h00;
          wd_q    <= '0;
          conn_q  <= 1'b0;
        end else begin
          valid_q <= w_valid[p];

          // A capture wins over a timeout landing on the same edge.
          if (w_capture) begin
            held_q <= mask_dpad(w_btn[p]);
            wd_q   <= '0;
            conn_q <= 1'b1;
          end else if (wd_q != c_wd_max) begin
            wd_q <= w_wd_inc;
            if (w_wd_inc == c_wd_max) begin
              held_q <= 8'h00;
              conn_q <= 1'b0;
            end
          end

          // Reload uses the pre-edge held value, so a fresh capture shows up
          // in the shifter one edge later.
          if (strobe_q) begin
            sh_q <= held_q;
          end else if (w_rd_sel) begin
            sh_q <= {1'b1, sh_q[7:1]};
          end
        end
      end
    end
  endgenerate

  // Strobe latch shared by both ports; reads on the same edge see the old value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      strobe_q <= 1'b0;
    end else if (bus.i_cpu_strobe_we) begin
      strobe_q <= bus.i_cpu_wdata0;
    end
  end

  // Registered read data, held until the next read of either port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q <= 1'b0;
    end else if (bus.i_cpu_rd) begin
      rdata_q <= w_sh0[bus.i_cpu_rd_port];
    end
  end

  assign bus.o_cpu_rdata    = rdata_q;
  assign bus.o_p1_connected = w_conn[0];
  assign bus.o_p2_connected = w_conn[1];

endmodule
`default_nettype wire
